// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
//   AW, DW, NREG : register address width, data width, register count
//   wb_req_t     : one pending write-back request (addr, data)
//   onehot_sel() : register address -> one-hot per-register write enable
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] onehot_sel(input logic [AW-1:0] addr);
    logic [NREG-1:0] sel;
    sel       = '0;
    sel[addr] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_fwd_lookup.sv
// Forwarding lookup for one read port.
// Searches the pending queue entries (presented oldest-first) and the write
// output register; the youngest matching write supplies the data.
//   rd_addr_i   : register being read
//   entries_i   : queue contents, index 0 = oldest, DEPTH-1 = newest slot
//   valid_i     : per-slot occupancy, same ordering as entries_i
//   out_valid_i : output register holds a write being committed
//   out_addr_i  : address in the output register
//   out_data_i  : data in the output register
//   hit_o       : a pending write to rd_addr_i exists
//   data_o      : youngest pending data for rd_addr_i, 0 on miss
module regfile_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   [AW-1:0] rd_addr_i,
  input  wb_req_t [DEPTH-1:0]             entries_i,
  input  logic                [DEPTH-1:0] valid_i,
  input  logic                            out_valid_i,
  input  logic                   [AW-1:0] out_addr_i,
  input  logic                   [DW-1:0] out_data_i,
  output logic                            hit_o,
  output logic                   [DW-1:0] data_o
);

  // Oldest candidate is evaluated first so each later match overrides it:
  // output register < older queue entries < newest queue entry.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    hit_o  = 1'b0;
    data_o = '0;
    if (out_valid_i && out_addr_i == rd_addr_i) begin
      hit_o  = 1'b1;
      data_o = out_data_i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && entries_i[i].addr == rd_addr_i) begin
        hit_o  = 1'b1;
        data_o = entries_i[i].data;
      end
    end
    // r0 is hardwired; it never forwards.
    if (rd_addr_i == '0) begin
      hit_o  = 1'b0;
      data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register-file write port.
// Buffers (addr, data) requests, commits at most one per cycle through a
// registered write port, and forwards the youngest pending value to two
// read ports so readers see writes that have not yet reached the regfile.
//   clk, clr_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake (in_ready = queue not full)
//   in_addr, in_data      : request payload; addr 0 is accepted and dropped
//   drain_en              : regfile accepts a write this cycle
//   wr_en, wr_sel, wr_data: registered regfile write (one-hot select)
//   rd_addr_a/b           : read addresses for forwarding
//   fwd_hit_a/b           : pending write exists for that address
//   fwd_data_a/b          : youngest pending data, 0 on miss
//   count                 : occupied queue entries
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     wr_en,
  output logic [NREG-1:0]          wr_sel,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            rd_addr_a,
  output logic                     fwd_hit_a,
  output logic [DW-1:0]            fwd_data_a,
  input  logic [AW-1:0]            rd_addr_b,
  output logic                     fwd_hit_b,
  output logic [DW-1:0]            fwd_data_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t           mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [NREG-1:0]   wr_sel_q, wr_sel_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [AW-1:0]     out_addr_q, out_addr_d;

  logic              push;
  logic              pop;

  // Ready ignores drain_en: a full queue refuses even when a pop happens
  // in the same cycle, which keeps in_ready off the drain_en timing path.
  assign in_ready = (count_q != CW'(DEPTH));
  // Addr 0 completes the handshake but is never stored.
  assign push     = in_valid && in_ready && (in_addr != '0);
  // Pop only sees entries stored at earlier edges: no same-cycle bypass.
  assign pop      = drain_en && (count_q != '0);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = '0;
    wr_data_d  = wr_data_q;
    out_addr_d = out_addr_q;
    if (pop) begin
      head_d     = head_q + 1'b1;
      wr_en_d    = 1'b1;
      wr_sel_d   = onehot_sel(mem_q[head_q].addr);
      wr_data_d  = mem_q[head_q].data;
      out_addr_d = mem_q[head_q].addr;
    end
    // Pointers are PW bits wide, so +1 wraps mod DEPTH on its own.
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!clr_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      out_addr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_data_q  <= wr_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; occupancy is tracked by
  // count/pointers, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{addr: in_addr, data: in_data};
    end
  end

  // Age-ordered view of the queue for forwarding: slot 0 is the head.
  wb_req_t [DEPTH-1:0] ord_entries;
  logic    [DEPTH-1:0] ord_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_entries[i] = mem_q[head_q + PW'(i)];
      ord_valid[i]   = (CW'(i) < count_q);
    end
  end

  regfile_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
    .rd_addr_i   (rd_addr_a),
    .entries_i   (ord_entries),
    .valid_i     (ord_valid),
    .out_valid_i (wr_en_q),
    .out_addr_i  (out_addr_q),
    .out_data_i  (wr_data_q),
    .hit_o       (fwd_hit_a),
    .data_o      (fwd_data_a)
  );

  regfile_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
    .rd_addr_i   (rd_addr_b),
    .entries_i   (ord_entries),
    .valid_i     (ord_valid),
    .out_valid_i (wr_en_q),
    .out_addr_i  (out_addr_q),
    .out_data_i  (wr_data_q),
    .hit_o       (fwd_hit_b),
    .data_o      (fwd_data_b)
  );

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: a directed vector table, hand
// sequences for full/reset/wrap corners, and randomized traffic against a
// queue-based reference model.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int NTBL  = 13;

  logic            clk = 1'b0;
  logic            clr_n;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_addr;
  logic [DW-1:0]   in_data;
  logic            drain_en;
  logic            wr_en;
  logic [NREG-1:0] wr_sel;
  logic [DW-1:0]   wr_data;
  logic [AW-1:0]   rd_addr_a;
  logic            fwd_hit_a;
  logic [DW-1:0]   fwd_data_a;
  logic [AW-1:0]   rd_addr_b;
  logic            fwd_hit_b;
  logic [DW-1:0]   fwd_data_b;
  logic [2:0]      count;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .drain_en   (drain_en),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_data_a (fwd_data_a),
    .rd_addr_b  (rd_addr_b),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_b (fwd_data_b),
    .count      (count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as a FIFO plus the committing write.
  wb_req_t         mq[$];
  logic            m_wr_en;
  logic [NREG-1:0] m_wr_sel;
  logic [DW-1:0]   m_wr_data;
  logic [AW-1:0]   m_out_addr;

  function automatic void m_reset();
    mq.delete();
    m_wr_en    = 1'b0;
    m_wr_sel   = '0;
    m_wr_data  = '0;
    m_out_addr = '0;
  endfunction

  // Applies one clock edge's worth of the queue rules to the model.
  function automatic void m_edge();
    bit      room;
    bit      do_push;
    bit      do_pop;
    wb_req_t h;
    room    = (mq.size() != DEPTH);
    do_push = in_valid && room && (in_addr != '0);
    do_pop  = drain_en && (mq.size() != 0);
    if (do_pop) begin
      h          = mq.pop_front();
      m_wr_en    = 1'b1;
      m_wr_sel   = NREG'(1) << h.addr;
      m_wr_data  = h.data;
      m_out_addr = h.addr;
    end else begin
      m_wr_en  = 1'b0;
      m_wr_sel = '0;
    end
    if (do_push) mq.push_back('{addr: in_addr, data: in_data});
  endfunction

  function automatic void m_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) begin
        hit = 1'b1;
        d   = mq[i].data;
        return;
      end
    end
    if (m_wr_en && m_out_addr == a) begin
      hit = 1'b1;
      d   = m_wr_data;
    end
  endfunction

  // Called at posedge+1; drives inputs, crosses one edge, returns at posedge+2.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic dr, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    drain_en  = dr;
    rd_addr_a = ra;
    rd_addr_b = rb;
    #1;
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic          h;
    logic [DW-1:0] d;
    check({tag, " count"},    64'(count),    64'(mq.size()));
    check({tag, " in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    check({tag, " wr_en"},    64'(wr_en),    64'(m_wr_en));
    check({tag, " wr_sel"},   64'(wr_sel),   64'(m_wr_sel));
    check({tag, " wr_data"},  64'(wr_data),  64'(m_wr_data));
    m_fwd(rd_addr_a, h, d);
    check({tag, " hit_a"},    64'(fwd_hit_a),  64'(h));
    check({tag, " data_a"},   64'(fwd_data_a), 64'(d));
    m_fwd(rd_addr_b, h, d);
    check({tag, " hit_b"},    64'(fwd_hit_b),  64'(h));
    check({tag, " data_b"},   64'(fwd_data_b), 64'(d));
  endtask

  typedef struct {
    logic            v;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            dr;
    logic [AW-1:0]   ra;
    logic [2:0]      e_count;
    logic            e_ready;
    logic            e_wr_en;
    logic [NREG-1:0] e_sel;
    logic [DW-1:0]   e_wdata;
    logic            e_hit;
    logic [DW-1:0]   e_fdata;
  } vec_t;

  vec_t tbl [NTBL];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got[$];

    // Expected state after each edge; rd_addr_b stays 0 throughout.
    //           v     a      d              dr    ra     cnt   rdy   wen   sel            wdata          hit   fdata
    tbl[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 3'd1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 3'd0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 3'd0, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 5'd7, 32'h1,         1'b0, 5'd7, 3'd1, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h1};
    tbl[4]  = '{1'b1, 5'd7, 32'h2,         1'b0, 5'd7, 3'd2, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h2};
    tbl[5]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 3'd2, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 3'd1, 1'b1, 1'b1, 32'h0000_0080, 32'h1,         1'b1, 32'h2};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 3'd0, 1'b1, 1'b1, 32'h0000_0080, 32'h2,         1'b1, 32'h2};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 3'd0, 1'b1, 1'b0, 32'h0000_0000, 32'h2,         1'b0, 32'h0};
    tbl[9]  = '{1'b1, 5'd3, 32'h33,        1'b1, 5'd3, 3'd1, 1'b1, 1'b0, 32'h0000_0000, 32'h2,         1'b1, 32'h33};
    tbl[10] = '{1'b1, 5'd4, 32'h44,        1'b1, 5'd3, 3'd1, 1'b1, 1'b1, 32'h0000_0008, 32'h33,        1'b1, 32'h33};
    tbl[11] = '{1'b1, 5'd0, 32'h99,        1'b1, 5'd0, 3'd0, 1'b1, 1'b1, 32'h0000_0010, 32'h44,        1'b0, 32'h0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd4, 3'd0, 1'b1, 1'b0, 32'h0000_0000, 32'h44,        1'b0, 32'h0};

    // Power-on reset.
    clr_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    drain_en  = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    m_reset();
    #12;
    check("reset count",    64'(count),    64'd0);
    check("reset wr_en",    64'(wr_en),    64'd0);
    check("reset wr_sel",   64'(wr_sel),   64'd0);
    check("reset wr_data",  64'(wr_data),  64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: single write, forward priority, addr 0, no bypass.
    for (int i = 0; i < NTBL; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dr, tbl[i].ra, 5'd0);
      check($sformatf("tbl%0d count", i),    64'(count),      64'(tbl[i].e_count));
      check($sformatf("tbl%0d in_ready", i), 64'(in_ready),   64'(tbl[i].e_ready));
      check($sformatf("tbl%0d wr_en", i),    64'(wr_en),      64'(tbl[i].e_wr_en));
      check($sformatf("tbl%0d wr_sel", i),   64'(wr_sel),     64'(tbl[i].e_sel));
      check($sformatf("tbl%0d wr_data", i),  64'(wr_data),    64'(tbl[i].e_wdata));
      check($sformatf("tbl%0d hit_a", i),    64'(fwd_hit_a),  64'(tbl[i].e_hit));
      check($sformatf("tbl%0d data_a", i),   64'(fwd_data_a), 64'(tbl[i].e_fdata));
      check($sformatf("tbl%0d hit_b", i),    64'(fwd_hit_b),  64'd0);
    end

    // Full queue: refuses pushes, with or without a concurrent pop.
    for (int i = 1; i <= 4; i++) cycle(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, 5'd0, 5'd0);
    check("full count",    64'(count),    64'd4);
    check("full in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 5'd6, 32'h600, 1'b0, 5'd6, 5'd0);
    check("full refuse count", 64'(count),     64'd4);
    check("full refuse hit",   64'(fwd_hit_a), 64'd0);
    cycle(1'b1, 5'd6, 32'h666, 1'b1, 5'd6, 5'd0);
    check("full pop refuse count",   64'(count),     64'd3);
    check("full pop refuse hit",     64'(fwd_hit_a), 64'd0);
    if (wr_en) got.push_back(wr_data);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd0);
      check_model($sformatf("drain%0d", k));
      if (wr_en) got.push_back(wr_data);
    end
    check("drain commit count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("drain order %0d", i), 64'(got[i]), 64'(32'h101 + i));
    end

    // Asynchronous reset mid-drain with three entries still queued.
    for (int i = 8; i < 12; i++) cycle(1'b1, AW'(i), DW'(32'h800 + i), 1'b0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0);
    check("pre-reset count", 64'(count), 64'd3);
    check("pre-reset wr_en", 64'(wr_en), 64'd1);
    drain_en = 1'b0;
    #1;
    clr_n = 1'b0;
    #1;
    check("async reset count",   64'(count),     64'd0);
    check("async reset wr_en",   64'(wr_en),     64'd0);
    check("async reset wr_sel",  64'(wr_sel),    64'd0);
    check("async reset wr_data", 64'(wr_data),   64'd0);
    check("async reset fwd",     64'(fwd_hit_a), 64'd0);
    m_reset();
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd10);
    check_model("post-reset");

    // Wrap: sustained push+pop keeps order through the pointer wrap.
    cycle(1'b1, 5'd9, DW'($urandom), 1'b1, 5'd9, 5'd0);
    check_model("wrap prime");
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(1, NREG - 1));
      cycle(1'b1, a, DW'($urandom), 1'b1, a, AW'($urandom_range(0, NREG - 1)));
      check_model($sformatf("wrap%0d", k));
      check($sformatf("wrap%0d count bound", k), 64'(count <= 3'd4), 64'd1);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      check_model($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
